// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared defaults and helpers
// for the 2R1W register bank and its scoreboard.
package register_bank_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/register_bank_busy_scoreboard.sv
// busy_scoreboard: per-register busy bits plus
// a registered running count of busy entries.
module busy_scoreboard
  import register_bank_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] tap_a,
  input  logic [ADDR_W-1:0] tap_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic [ADDR_W:0] ONE = 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [ADDR_W:0]  cnt_d;
  logic             set_new;
  logic             clr_hit;

  // next busy vector and count; a same-edge set beats clear and flush
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = busy_cnt;
    set_new = set_en && !busy_q[set_addr];
    clr_hit = clr_en && busy_q[clr_addr]
              && !(set_en && set_addr == clr_addr);
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
      if (set_en) begin
        busy_d[set_addr] = 1'b1;
        cnt_d            = ONE;
      end
    end else begin
      if (clr_en)
        busy_d[clr_addr] = 1'b0;
      if (set_en)
        busy_d[set_addr] = 1'b1;
      if (set_new)
        cnt_d = cnt_d + ONE;
      if (clr_hit)
        cnt_d = cnt_d - ONE;
    end
  end

  // busy state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  assign busy_a = busy_q[tap_a];
  assign busy_b = busy_q[tap_b];

endmodule

// File: rtl/register_bank_2r1w.sv
// register_bank_2r1w: 1W/2R register bank with busy scoreboard.
// Define REGISTER_BANK_BYPASS_EN for same-cycle write-to-read forwarding.
module register_bank_2r1w
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rsv_ok;
  logic              sb_busy_a;
  logic              sb_busy_b;

  assign wr_ok  = wr_en  && !(ZR && wr_addr  == '0);
  assign rsv_ok = rsv_en && !(ZR && rsv_addr == '0);

  busy_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rsv_ok),
    .set_addr (rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .flush    (flush),
    .tap_a    (rd_addr_a),
    .tap_b    (rd_addr_b),
    .busy_a   (sb_busy_a),
    .busy_b   (sb_busy_b),
    .busy_cnt (busy_cnt)
  );

  // data array; a hardwired zero register is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read port A: stored state, zero reg, optional forward
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    rd_busy_a = sb_busy_a;
    if (ZR && rd_addr_a == '0) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_ok && wr_addr == rd_addr_a) begin
      rd_data_a = wr_data;
      rd_busy_a = !(rsv_ok && rsv_addr == wr_addr);
    end
`endif
  end

  // read port B: stored state, zero reg, optional forward
  always_comb begin
    rd_data_b = mem[rd_addr_b];
    rd_busy_b = sb_busy_b;
    if (ZR && rd_addr_b == '0) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_ok && wr_addr == rd_addr_b) begin
      rd_data_b = wr_data;
      rd_busy_b = !(rsv_ok && rsv_addr == wr_addr);
    end
`endif
  end

endmodule

// File: tb/tb_register_bank_2r1w.sv
// tb_register_bank_2r1w: directed and random checks
// of the register bank against a reference model.
module tb_register_bank_2r1w;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsv_en;
  logic [4:0] rsv_addr;
  logic       flush;
  logic [4:0] rd_addr_a;
  logic [7:0] rd_data_a;
  logic       rd_busy_a;
  logic [4:0] rd_addr_b;
  logic [7:0] rd_data_b;
  logic       rd_busy_b;
  logic [5:0] busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_data [32];
  bit         m_busy [32];

  register_bank_2r1w #(
    .DATA_W   (8),
    .DEPTH    (32),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_busy_a (rd_busy_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .rd_busy_b (rd_busy_b),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int a);
    if (a == 0) return 8'h00;
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return m_data[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_en && int'(wr_addr) == a)
      return !(rsv_en && rsv_addr == wr_addr);
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++)
      if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (flush)
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    if (wr_en && wr_addr != 0) begin
      m_data[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (rsv_en && rsv_addr != 0)
      m_busy[rsv_addr] = 1'b1;
  endtask

  task automatic check_ports();
    chk("rd_data_a", rd_data_a, exp_data(rd_addr_a));
    chk("rd_busy_a", rd_busy_a, exp_busy(rd_addr_a));
    chk("rd_data_b", rd_data_b, exp_data(rd_addr_b));
    chk("rd_busy_b", rd_busy_b, exp_busy(rd_addr_b));
    chk("busy_cnt", busy_cnt, exp_cnt());
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0; flush = 0;
  endtask

  // check pre-edge view, clock, update model, drop strobes
  task automatic tick();
    #1;
    check_ports();
    @(posedge clk);
    model_edge();
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    rd_addr_a = 0;
    rd_addr_b = 0;
    reset = 1'b0;
    model_reset();
    #12;
    chk("rst_cnt", busy_cnt, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: async reset mid-run clears everything
    wr_en = 1; wr_addr = 4; wr_data = 8'h44;
    tick();
    rsv_en = 1; rsv_addr = 6;
    tick();
    rd_addr_a = 4; #1;
    chk("t1_pre", rd_data_a, 8'h44);
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("t1_cnt", busy_cnt, 0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i); #1;
      chk("t1_da", rd_data_a, 0);
      chk("t1_db", rd_data_b, 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    // 2: write then read both ports
    rd_addr_a = 1; rd_addr_b = 1;
    wr_en = 1; wr_addr = 1; wr_data = 8'h01;
    tick();
    chk("t2_a", rd_data_a, 8'h01);
    chk("t2_b", rd_data_b, 8'h01);
    chk("t2_ba", rd_busy_a, 0);

    // 3: reserve, reserve, clearing write
    rsv_en = 1; rsv_addr = 4;
    tick();
    chk("t3_c1", busy_cnt, 1);
    rsv_en = 1; rsv_addr = 7;
    tick();
    chk("t3_c2", busy_cnt, 2);
    rd_addr_a = 4; #1;
    chk("t3_b4", rd_busy_a, 1);
    wr_en = 1; wr_addr = 4; wr_data = 8'h04;
    tick();
    chk("t3_c3", busy_cnt, 1);
    chk("t3_b4c", rd_busy_a, 0);
    chk("t3_d4", rd_data_a, 8'h04);

    // 4: same-edge reserve and write
    rd_addr_a = 5;
    rsv_en = 1; rsv_addr = 5;
    wr_en = 1; wr_addr = 5; wr_data = 8'h55;
    tick();
    chk("t4_d", rd_data_a, 8'h55);
    chk("t4_b", rd_busy_a, 1);
    chk("t4_c", busy_cnt, 2);

    // re-reserve of busy reg leaves count alone
    rsv_en = 1; rsv_addr = 5;
    tick();
    chk("t4_rr", busy_cnt, 2);

    // 5: zero register ignores write and reserve
    rd_addr_a = 0;
    wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
    rsv_en = 1; rsv_addr = 0;
    tick();
    chk("t5_d", rd_data_a, 0);
    chk("t5_b", rd_busy_a, 0);
    chk("t5_c", busy_cnt, 2);

    // 6: fill, then flush with same-edge reserve
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1; rsv_addr = 5'(i);
      tick();
    end
    chk("t6_full", busy_cnt, 31);
    flush = 1; rsv_en = 1; rsv_addr = 9;
    wr_en = 1; wr_addr = 3; wr_data = 8'h33;
    tick();
    chk("t6_cnt", busy_cnt, 1);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); #1;
      chk("t6_busy", rd_busy_a, (i == 9) ? 1 : 0);
    end
    rd_addr_b = 3; #1;
    chk("t6_wd", rd_data_b, 8'h33);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = 8'($urandom);
      rsv_en    = 1'($urandom_range(0, 1));
      rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr
                                              : 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 19) == 0);
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr
                                              : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a
                                              : 5'($urandom_range(0, 31));
      tick();
    end
    #1;
    check_ports();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
